// File: rtl/memu_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package memu_pkg;

  localparam int unsigned RF_ZIP_W = 6;
  localparam int unsigned WB_ZIP_W = 38;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } mem_state_e;

endpackage

// File: rtl/memu_if.sv
// Data-SRAM bus (req/addr_ok/data_ok) between the MEM stage and data memory.
interface memu_if;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/memu_req_fsm.sv
// Tracks the single outstanding data-SRAM access and buffers load data while WB stalls.
module memu_req_fsm
  import memu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        wb_allowin,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output mem_state_e  state,
  output logic        data_req,
  output logic        op_ready,
  output logic [31:0] rdata_buf
);

  mem_state_e  state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    data_req    = 1'b0;
    op_ready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReq;
      end
      StReq: begin
        data_req = 1'b1;
        if (data_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (data_data_ok) begin
          op_ready    = 1'b1;
          rdata_buf_d = data_rdata;
          // A new access can only be accepted here when WB drains the current one.
          if (!wb_allowin)  state_d = StDone;
          else if (start)   state_d = StReq;
          else              state_d = StIdle;
        end
      end
      StDone: begin
        op_ready = 1'b1;
        if (wb_allowin) state_d = start ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rdata_buf_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign state     = state_q;
  assign rdata_buf = rdata_buf_q;

endmodule

// File: rtl/memu.sv
// MEM stage: latches the EXE payload, performs one data-SRAM access and hands off to WB.
module memu
  import memu_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                exe_to_mem_valid,
  input  logic [31:0]         exe_pc,
  input  logic [31:0]         exe_alu_result,
  input  logic                exe_res_from_mem,
  input  logic                exe_mem_we,
  input  logic [31:0]         exe_rkd_value,
  input  logic [RF_ZIP_W-1:0] exe_rf_zip,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [31:0]         mem_pc,
  output logic [WB_ZIP_W-1:0] mem_rf_zip,
  output logic                mem_blk,
  memu_if.master              dbus
);

  logic                mem_valid_q;
  logic [31:0]         pc_q;
  logic [31:0]         alu_result_q;
  logic                res_from_mem_q;
  logic                mem_we_q;
  logic [31:0]         rkd_value_q;
  logic [RF_ZIP_W-1:0] rf_zip_q;

  mem_state_e  state;
  logic        op_ready;
  logic [31:0] rdata_buf;
  logic        accept;
  logic        mem_ready_go;
  logic [31:0] rf_wdata;

  assign accept       = exe_to_mem_valid & mem_allowin;
  assign mem_ready_go = ~(res_from_mem_q | mem_we_q) | op_ready;
  assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);

  // mem_valid only drops once WB can take the result, so an in-flight access is never lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= 32'h0;
      alu_result_q   <= 32'h0;
      res_from_mem_q <= 1'b0;
      mem_we_q       <= 1'b0;
      rkd_value_q    <= 32'h0;
      rf_zip_q       <= '0;
    end else if (accept) begin
      mem_valid_q    <= 1'b1;
      pc_q           <= exe_pc;
      alu_result_q   <= exe_alu_result;
      res_from_mem_q <= exe_res_from_mem;
      mem_we_q       <= exe_mem_we;
      rkd_value_q    <= exe_rkd_value;
      rf_zip_q       <= exe_rf_zip;
    end else if (mem_allowin) begin
      mem_valid_q    <= 1'b0;
    end
  end

  memu_req_fsm u_req_fsm (
    .clk          (clk),
    .resetn       (resetn),
    .start        (accept & (exe_res_from_mem | exe_mem_we)),
    .wb_allowin   (wb_allowin),
    .data_addr_ok (dbus.data_addr_ok),
    .data_data_ok (dbus.data_data_ok),
    .data_rdata   (dbus.data_rdata),
    .state        (state),
    .data_req     (dbus.data_req),
    .op_ready     (op_ready),
    .rdata_buf    (rdata_buf)
  );

  assign dbus.data_wr    = mem_we_q;
  assign dbus.data_wstrb = mem_we_q ? 4'hf : 4'h0;
  assign dbus.data_addr  = alu_result_q;
  assign dbus.data_wdata = rkd_value_q;

  always_comb begin
    rf_wdata = alu_result_q;
    if (res_from_mem_q) rf_wdata = (state == StWait) ? dbus.data_rdata : rdata_buf;
  end

  assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
  assign mem_pc          = pc_q;
  assign mem_rf_zip      = {rf_zip_q[5] & ~mem_we_q, rf_zip_q[4:0], rf_wdata};
  assign mem_blk         = mem_valid_q & res_from_mem_q & ~mem_ready_go;

endmodule

// File: tb/tb_memu.sv
// Directed bench for the MEM stage: handshake, load/store bus timing, WB stall, reset.
module tb_memu;

  logic        clk;
  logic        resetn;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [31:0] exe_pc;
  logic [31:0] exe_alu_result;
  logic        exe_res_from_mem;
  logic        exe_mem_we;
  logic [31:0] exe_rkd_value;
  logic [5:0]  exe_rf_zip;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [37:0] mem_rf_zip;
  logic        mem_blk;

  int checks = 0;
  int failures = 0;

  memu_if dbus ();

  memu dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_pc           (exe_pc),
    .exe_alu_result   (exe_alu_result),
    .exe_res_from_mem (exe_res_from_mem),
    .exe_mem_we       (exe_mem_we),
    .exe_rkd_value    (exe_rkd_value),
    .exe_rf_zip       (exe_rf_zip),
    .wb_allowin       (wb_allowin),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_pc           (mem_pc),
    .mem_rf_zip       (mem_rf_zip),
    .mem_blk          (mem_blk),
    .dbus             (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                       input logic st, input logic [31:0] rkd, input logic [5:0] zip);
    exe_to_mem_valid = 1'b1;
    exe_pc           = pc;
    exe_alu_result   = alu;
    exe_res_from_mem = ld;
    exe_mem_we       = st;
    exe_rkd_value    = rkd;
    exe_rf_zip       = zip;
  endtask

  initial begin
    resetn = 1'b0;
    exe_to_mem_valid = 1'b0;
    exe_pc = '0; exe_alu_result = '0; exe_res_from_mem = 1'b0; exe_mem_we = 1'b0;
    exe_rkd_value = '0; exe_rf_zip = '0; wb_allowin = 1'b1;
    dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 64'(mem_to_wb_valid), 64'h0);
    chk("rst_allowin", 64'(mem_allowin), 64'h1);
    chk("rst_pc", 64'(mem_pc), 64'h0);
    chk("rst_zip", 64'(mem_rf_zip), 64'h0);
    chk("rst_blk", 64'(mem_blk), 64'h0);
    chk("rst_req", 64'(dbus.data_req), 64'h0);
    chk("rst_bus", 64'({dbus.data_wr, dbus.data_wstrb, dbus.data_addr, dbus.data_wdata}), 64'h0);
    resetn = 1'b1;
    tick();

    // Non-memory instruction: one-cycle residency
    issue(32'h1c00_0000, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 6'h23);
    settle();
    chk("alu_allowin", 64'(mem_allowin), 64'h1);
    tick();
    exe_to_mem_valid = 1'b0;
    settle();
    chk("alu_valid", 64'(mem_to_wb_valid), 64'h1);
    chk("alu_zip", 64'(mem_rf_zip), 64'h23_0000_1234);
    chk("alu_pc", 64'(mem_pc), 64'h1c00_0000);
    chk("alu_req", 64'(dbus.data_req), 64'h0);
    chk("alu_blk", 64'(mem_blk), 64'h0);
    tick();
    chk("alu_drain", 64'(mem_to_wb_valid), 64'h0);

    // Load, zero wait
    issue(32'h1c00_0004, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 6'h25);
    tick();
    exe_to_mem_valid = 1'b0;
    dbus.data_addr_ok = 1'b1;
    settle();
    chk("ld0_req", 64'(dbus.data_req), 64'h1);
    chk("ld0_addr", 64'(dbus.data_addr), 64'h1000);
    chk("ld0_wr_strb", 64'({dbus.data_wr, dbus.data_wstrb}), 64'h0);
    chk("ld0_blk", 64'(mem_blk), 64'h1);
    chk("ld0_notvalid", 64'(mem_to_wb_valid), 64'h0);
    chk("ld0_allowin", 64'(mem_allowin), 64'h0);
    tick();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("ld0_valid", 64'(mem_to_wb_valid), 64'h1);
    chk("ld0_zip", 64'(mem_rf_zip), 64'h25_DEAD_BEEF);
    chk("ld0_req_wait", 64'(dbus.data_req), 64'h0);
    chk("ld0_blk_done", 64'(mem_blk), 64'h0);
    chk("ld0_allowin_done", 64'(mem_allowin), 64'h1);
    tick();
    dbus.data_data_ok = 1'b0;
    settle();
    chk("ld0_drain", 64'(mem_to_wb_valid), 64'h0);

    // Load with addr_ok delayed three cycles; a late data_ok must not complete it early
    issue(32'h1c00_0008, 32'h0000_3008, 1'b1, 1'b0, 32'h0, 6'h26);
    tick();
    exe_to_mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dbus.data_data_ok = (i == 1);
      settle();
      chk("ld3_req", 64'(dbus.data_req), 64'h1);
      chk("ld3_addr", 64'(dbus.data_addr), 64'h3008);
      chk("ld3_allowin", 64'(mem_allowin), 64'h0);
      chk("ld3_valid", 64'(mem_to_wb_valid), 64'h0);
      tick();
    end
    dbus.data_data_ok = 1'b0;
    dbus.data_addr_ok = 1'b1;
    settle();
    chk("ld3_req_ok", 64'(dbus.data_req), 64'h1);
    tick();
    dbus.data_addr_ok = 1'b0;
    settle();
    chk("ld3_wait_req", 64'(dbus.data_req), 64'h0);
    chk("ld3_wait_blk", 64'(mem_blk), 64'h1);
    chk("ld3_wait_valid", 64'(mem_to_wb_valid), 64'h0);
    tick();
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h1111_2222;
    settle();
    chk("ld3_zip", 64'(mem_rf_zip), 64'h26_1111_2222);
    chk("ld3_valid_done", 64'(mem_to_wb_valid), 64'h1);
    tick();
    dbus.data_data_ok = 1'b0;

    // Store: rf_we suppressed, bus carries full-word write
    issue(32'h1c00_000c, 32'h0000_2004, 1'b0, 1'b1, 32'hCAFE_F00D, 6'h27);
    tick();
    exe_to_mem_valid = 1'b0;
    dbus.data_addr_ok = 1'b1;
    settle();
    chk("st_req", 64'(dbus.data_req), 64'h1);
    chk("st_wr_strb", 64'({dbus.data_wr, dbus.data_wstrb}), 64'h1f);
    chk("st_addr", 64'(dbus.data_addr), 64'h2004);
    chk("st_wdata", 64'(dbus.data_wdata), 64'hCAFE_F00D);
    chk("st_blk", 64'(mem_blk), 64'h0);
    tick();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    settle();
    chk("st_valid", 64'(mem_to_wb_valid), 64'h1);
    chk("st_zip", 64'(mem_rf_zip), 64'h07_0000_2004);
    tick();
    dbus.data_data_ok = 1'b0;

    // WB stall at data_ok: buffered data survives rdata changing
    issue(32'h1c00_0010, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 6'h22);
    tick();
    exe_to_mem_valid = 1'b0;
    dbus.data_addr_ok = 1'b1;
    tick();
    dbus.data_addr_ok = 1'b0;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'hA5A5_A5A5;
    wb_allowin        = 1'b0;
    settle();
    chk("stall_valid0", 64'(mem_to_wb_valid), 64'h1);
    chk("stall_allowin0", 64'(mem_allowin), 64'h0);
    tick();
    dbus.data_data_ok = 1'b0;
    dbus.data_rdata   = 32'h0BAD_F00D;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("stall_valid", 64'(mem_to_wb_valid), 64'h1);
      chk("stall_zip", 64'(mem_rf_zip), 64'h22_A5A5_A5A5);
      chk("stall_allowin", 64'(mem_allowin), 64'h0);
      chk("stall_blk", 64'(mem_blk), 64'h0);
      tick();
    end
    // Release WB and accept the next load in the same cycle
    wb_allowin = 1'b1;
    issue(32'h1c00_0014, 32'h0000_5000, 1'b1, 1'b0, 32'h0, 6'h28);
    settle();
    chk("b2b_allowin", 64'(mem_allowin), 64'h1);
    chk("b2b_zip", 64'(mem_rf_zip), 64'h22_A5A5_A5A5);
    tick();
    exe_to_mem_valid = 1'b0;
    settle();
    chk("b2b_req", 64'(dbus.data_req), 64'h1);
    chk("b2b_addr", 64'(dbus.data_addr), 64'h5000);
    chk("b2b_pc", 64'(mem_pc), 64'h1c00_0014);
    dbus.data_addr_ok = 1'b1;
    tick();
    dbus.data_addr_ok = 1'b0;

    // Reset while waiting for data_ok; late data_ok must be ignored
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata   = 32'h7777_7777;
    settle();
    chk("rw_valid", 64'(mem_to_wb_valid), 64'h0);
    chk("rw_zip", 64'(mem_rf_zip), 64'h0);
    chk("rw_pc", 64'(mem_pc), 64'h0);
    chk("rw_blk", 64'(mem_blk), 64'h0);
    chk("rw_bus", 64'({dbus.data_req, dbus.data_wr, dbus.data_wstrb, dbus.data_addr}), 64'h0);
    chk("rw_allowin", 64'(mem_allowin), 64'h1);
    tick();
    dbus.data_data_ok = 1'b0;
    settle();
    chk("rw_late_req", 64'(dbus.data_req), 64'h0);
    chk("rw_late_valid", 64'(mem_to_wb_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
